branch_target_unit: RTL and testbench

- Program-counter sequencer for the 16-bit multicycle datapath.
- Consumes the word-scaled branch offset (sign-extended immediate shifted left by one) and owns the PC register.
- Computes PC+2 in FETCH, latches the branch target in DECODE, and commits the next PC in RESOLVE once the ALU reports the branch outcome.
- Feeds instruction-memory address and the IR load strobe.

---
 rtl/dp_pkg.sv | 26 ++
 rtl/branch_adder.sv | 24 ++
 rtl/branch_target_unit.sv | 153 +++++++++++++++
 tb/tb_branch_target_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_pkg
// Description : Shared definitions for the 16-bit multicycle datapath.
//               Holds the sequencer phase encoding and the PC step size,
//               so the controller and the branch target unit agree on them.
// Contents    : c_phase_w     - width of the phase/state encoding
//               c_instr_bytes - PC increment per instruction
//               state_t       - FETCH/DECODE/RESOLVE phase encoding
// Revision    : 1.0 - initial release
// ============================================================================
package dp_pkg;

    localparam int c_phase_w     = 2;
    localparam int c_instr_bytes = 2;

    // Code 2'd3 is deliberately left unassigned; it is treated as illegal.
    typedef enum logic [c_phase_w-1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        RESOLVE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/branch_adder.sv
`default_nettype none
// ============================================================================
// Module      : branch_adder
// Description : Purely combinational WIDTH-bit adder. The sum wraps modulo
//               2^WIDTH, which gives two's-complement behaviour for signed
//               branch offsets.
// Ports       : i_a   [WIDTH-1:0] - first operand
//               i_b   [WIDTH-1:0] - second operand
//               o_sum [WIDTH-1:0] - i_a + i_b, carry out discarded
// Revision    : 1.0 - initial release
// ============================================================================
module branch_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

`default_nettype wire

// File: rtl/branch_target_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_unit
// Description : Program-counter sequencer for the 16-bit multicycle datapath.
//               FETCH computes PC+INSTR_BYTES. DECODE latches the branch
//               target, which is pc_plus2 + extshift. RESOLVE commits the
//               next PC once the ALU reports the branch outcome.
// Ports       : clk           - system clock, rising edge
//               reset         - synchronous, active-high reset
//               stall         - freezes state and registers
//               extshift      - word-scaled signed branch offset (DECODE)
//               is_branch     - conditional branch (RESOLVE)
//               is_jump       - absolute jump (RESOLVE)
//               jump_addr     - absolute jump target, bit 0 ignored
//               zero          - ALU zero flag, branch taken when 1
//               resolve_valid - ALU flags valid this cycle
//               pc            - current PC / instruction-memory address
//               pc_plus2      - registered PC + INSTR_BYTES
//               branch_target - registered pc_plus2 + extshift
//               ir_load       - instruction register load strobe (FETCH)
//               taken         - one-cycle redirect strobe
//               phase         - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_unit
    import dp_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               INSTR_BYTES = c_instr_bytes
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [WIDTH-1:0]     extshift,
    input  logic                 is_branch,
    input  logic                 is_jump,
    input  logic [WIDTH-1:0]     jump_addr,
    input  logic                 zero,
    input  logic                 resolve_valid,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus2,
    output logic [WIDTH-1:0]     branch_target,
    output logic                 ir_load,
    output logic                 taken,
    output logic [c_phase_w-1:0] phase
);

    localparam logic [WIDTH-1:0] c_inc        = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] c_align_mask = {{(WIDTH-1){1'b1}}, 1'b0};

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pc_plus2;
    logic [WIDTH-1:0] r_branch_target;
    logic             r_taken;

    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_target;
    logic             w_commit;
    logic             w_redirect;
    logic [WIDTH-1:0] w_pc_next;

    // PC + INSTR_BYTES, consumed in FETCH.
    branch_adder #(
        .WIDTH (WIDTH)
    ) u_inc_adder (
        .i_a   (r_pc),
        .i_b   (c_inc),
        .o_sum (w_pc_inc)
    );

    // pc_plus2 + extshift, consumed in DECODE.
    branch_adder #(
        .WIDTH (WIDTH)
    ) u_target_adder (
        .i_a   (r_pc_plus2),
        .i_b   (extshift),
        .o_sum (w_target)
    );

    // A resolve presented under stall is dropped, so the controller has to
    // present it again.
    assign w_commit   = (r_state == RESOLVE) && resolve_valid && !stall;
    assign w_redirect = is_jump || (is_branch && zero);

    always_comb begin
        w_pc_next = r_pc_plus2;
        if (is_jump) begin
            w_pc_next = jump_addr & c_align_mask;
        end else if (is_branch && zero) begin
            w_pc_next = r_branch_target;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else if (!stall) begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:   w_state_next = DECODE;
            DECODE:  w_state_next = RESOLVE;
            RESOLVE: if (resolve_valid) w_state_next = FETCH;
            default: w_state_next = FETCH;  // illegal code 2'd3 recovers
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_pc_plus2      <= RESET_PC + c_inc;
            r_branch_target <= '0;
            r_taken         <= 1'b0;
        end else begin
            // taken is a pulse. It must also clear while stalled.
            r_taken <= w_commit && w_redirect;
            if (!stall) begin
                case (r_state)
                    FETCH:   r_pc_plus2      <= w_pc_inc;
                    DECODE:  r_branch_target <= w_target;
                    RESOLVE: if (resolve_valid) r_pc <= w_pc_next;
                    default: ;
                endcase
            end
        end
    end

    assign pc            = r_pc;
    assign pc_plus2      = r_pc_plus2;
    assign branch_target = r_branch_target;
    assign taken         = r_taken;
    assign phase         = r_state;
    assign ir_load       = (r_state == FETCH) && !stall && !reset;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_unit
// Description : Self-checking bench for branch_target_unit. It drives
//               directed instructions and then random ones. An
//               instruction-level model predicts PC, target and taken.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic [W-1:0] extshift;
    logic         is_branch;
    logic         is_jump;
    logic [W-1:0] jump_addr;
    logic         zero;
    logic         resolve_valid;
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus2;
    logic [W-1:0] branch_target;
    logic         ir_load;
    logic         taken;
    logic [1:0]   phase;

    int errors = 0;
    int checks = 0;

    // Instruction-level model state
    logic [W-1:0] m_pc;
    logic         m_taken;

    branch_target_unit #(
        .WIDTH       (16),
        .RESET_PC    (16'h0000),
        .INSTR_BYTES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .extshift      (extshift),
        .is_branch     (is_branch),
        .is_jump       (is_jump),
        .jump_addr     (jump_addr),
        .zero          (zero),
        .resolve_valid (resolve_valid),
        .pc            (pc),
        .pc_plus2      (pc_plus2),
        .branch_target (branch_target),
        .ir_load       (ir_load),
        .taken         (taken),
        .phase         (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction, entered and left in the FETCH phase.
    task automatic run_instr(input logic [W-1:0] ext, input logic br, input logic jmp,
                             input logic [W-1:0] ja, input logic z,
                             input int fstalls, input int waits, input int rstalls);
        logic [W-1:0] exp_tgt;
        logic [W-1:0] exp_next;
        logic         exp_taken;
        exp_tgt   = m_pc + 16'd2 + ext;
        exp_taken = jmp | (br & z);
        exp_next  = jmp ? (ja & 16'hFFFE) : ((br & z) ? exp_tgt : m_pc + 16'd2);

        chk("fetch_phase", 16'(phase), 16'd0);
        chk("fetch_pc", pc, m_pc);
        chk("fetch_irload", 16'(ir_load), 16'd1);
        chk("fetch_taken", 16'(taken), 16'(m_taken));
        for (int i = 0; i < fstalls; i++) begin
            stall = 1'b1;
            #1;
            chk("fstall_irload", 16'(ir_load), 16'd0);
            step();
            chk("fstall_phase", 16'(phase), 16'd0);
            chk("fstall_taken", 16'(taken), 16'd0);
        end
        stall    = 1'b0;
        extshift = ext;
        step();
        chk("decode_phase", 16'(phase), 16'd1);
        chk("decode_pcp2", pc_plus2, m_pc + 16'd2);
        chk("decode_irload", 16'(ir_load), 16'd0);
        step();
        chk("resolve_phase", 16'(phase), 16'd2);
        chk("resolve_target", branch_target, exp_tgt);
        is_branch = br;
        is_jump   = jmp;
        jump_addr = ja;
        zero      = z;
        for (int i = 0; i < waits; i++) begin
            step();
            chk("wait_phase", 16'(phase), 16'd2);
            chk("wait_pc", pc, m_pc);
        end
        resolve_valid = 1'b1;
        for (int i = 0; i < rstalls; i++) begin
            stall = 1'b1;
            step();
            chk("rstall_phase", 16'(phase), 16'd2);
            chk("rstall_pc", pc, m_pc);
            chk("rstall_taken", 16'(taken), 16'd0);
        end
        stall = 1'b0;
        step();
        resolve_valid = 1'b0;
        is_branch     = 1'b0;
        is_jump       = 1'b0;
        zero          = 1'b0;
        chk("commit_pc", pc, exp_next);
        m_pc    = exp_next;
        m_taken = exp_taken;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; extshift = '0; is_branch = 1'b0; is_jump = 1'b0;
        jump_addr = '0; zero = 1'b0; resolve_valid = 1'b0;
        step();
        step();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_pcp2", pc_plus2, 16'h0002);
        chk("rst_target", branch_target, 16'h0000);
        chk("rst_taken", 16'(taken), 16'd0);
        chk("rst_irload", 16'(ir_load), 16'd0);
        chk("rst_phase", 16'(phase), 16'd0);
        reset   = 1'b0;
        #1;
        m_pc    = 16'h0000;
        m_taken = 1'b0;

        // Sequential up to pc=0x0010
        for (int i = 0; i < 8; i++) run_instr(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 0);
        // Taken forward branch
        run_instr(16'h0008, 1'b1, 1'b0, 16'h0000, 1'b1, 0, 0, 0);
        chk("br_fwd_pc", pc, 16'h001A);
        // Jump back to 0x0010, then a backward branch that is not taken
        run_instr(16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 0, 0, 0);
        run_instr(16'hFFF0, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 0, 0);
        chk("br_nt_pc", pc, 16'h0012);
        chk("br_nt_taken", 16'(taken), 16'd0);
        // Backward wrap of the target from pc=0
        run_instr(16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 0, 0);
        run_instr(16'hFFFC, 1'b1, 1'b0, 16'h0000, 1'b1, 0, 0, 0);
        chk("wrap_back_pc", pc, 16'hFFFE);
        // Forward wrap of the sequential PC
        run_instr(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 0);
        chk("wrap_fwd_pc", pc, 16'h0000);
        // Jump beats branch, bit 0 masked
        run_instr(16'h0040, 1'b1, 1'b1, 16'h1235, 1'b1, 0, 0, 0);
        chk("jmp_pc", pc, 16'h1234);
        // Resolve wait, then resolve under stall
        run_instr(16'h0004, 1'b1, 1'b0, 16'h0000, 1'b1, 1, 4, 2);
        chk("stall_pc", pc, 16'h123A);

        // Reset in DECODE
        step();
        chk("mid_decode", 16'(phase), 16'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 16'h0000);
        chk("mid_rst_phase", 16'(phase), 16'd0);
        m_pc    = 16'h0000;
        m_taken = 1'b0;

        // Random instructions
        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] ext;
            logic [W-1:0] ja;
            ext = 16'($urandom) & 16'hFFFE;
            ja  = 16'($urandom);
            run_instr(ext, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                      ja, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        chk("final_taken", 16'(taken), 16'(m_taken));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
